// File: rtl/rx_lane_align_sequencer.sv
// Sequences per-lane bit-alignment training engines one lane at a time after PLL lock,
// with retries and aggregate status. Optional macro RX_ALGN_PERIODIC_RETRAIN_EN adds timed re-sequencing.
module rx_lane_align_sequencer #(
    parameter int NUM_LANES       = 4,
    parameter int LOCK_STABLE_CYC = 256,
    parameter int TIMEOUT_CYC     = 65535,
`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
    parameter int RETRAIN_PERIOD  = 1 << 24,
`endif
    parameter int MAX_RETRY       = 3
) (
    input  logic                                             SCLK,
    input  logic                                             RESET,
    input  logic                                             PLL_LOCK,
    input  logic                                             ALIGN_REQ,
    input  logic [NUM_LANES-1:0]                             LANE_START,
    input  logic [NUM_LANES-1:0]                             LANE_DONE,
    input  logic [NUM_LANES-1:0]                             LANE_ERR,
    output logic [NUM_LANES-1:0]                             LANE_RSTRT,
    output logic [NUM_LANES-1:0]                             LANE_HOLD,
    output logic [NUM_LANES-1:0]                             LANE_OK,
    output logic [(NUM_LANES > 1 ? $clog2(NUM_LANES) : 1)-1:0] ACTIVE_LANE,
    output logic                                             ALIGN_BUSY,
    output logic                                             ALIGN_DONE,
    output logic                                             ALIGN_FAIL
);

    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LOCK_W  = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RETRY_W = 3;

    localparam logic [LANE_W-1:0]  LANE_LAST  = LANE_W'(NUM_LANES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
    localparam int PER_W = (RETRAIN_PERIOD > 1) ? $clog2(RETRAIN_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(RETRAIN_PERIOD - 1);
    logic [PER_W-1:0] period_q, period_d;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOCK_WAIT,
        ISSUE,
        WAIT,
        NEXT,
        COMPLETE
    } state_t;

    state_t              state_q, state_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                armed_q, armed_d;
    logic [NUM_LANES-1:0] rstrt_q, rstrt_d;
    logic [NUM_LANES-1:0] hold_q, hold_d;
    logic [NUM_LANES-1:0] lane_ok_q, lane_ok_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;

    function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_W-1:0] idx);
        lane_bit = NUM_LANES'(1) << idx;
    endfunction

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        tmo_cnt_d  = tmo_cnt_q;
        retry_d    = retry_q;
        lane_d     = lane_q;
        armed_d    = armed_q;
        rstrt_d    = '0;
        hold_d     = hold_q;
        lane_ok_d  = lane_ok_q;
        done_d     = done_q;
        fail_d     = fail_q;
`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
        period_d   = '0;
`endif

        unique case (state_q)
            IDLE: state_d = LOCK_WAIT;
            LOCK_WAIT: begin
                if (PLL_LOCK) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d = ISSUE;
                        lane_d  = '0;
                        retry_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end
            end
            ISSUE: begin
                armed_d   = 1'b0;
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (LANE_START[lane_q]) armed_d = 1'b1;
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // ERR and timeout take precedence over a same-cycle DONE.
                if (LANE_ERR[lane_q] || (tmo_cnt_q == TMO_LAST)) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ISSUE;
                    end else begin
                        lane_ok_d[lane_q] = 1'b0;
                        state_d           = NEXT;
                    end
                end else if (armed_q && LANE_DONE[lane_q]) begin
                    lane_ok_d[lane_q] = 1'b1;
                    state_d           = NEXT;
                end
            end
            NEXT: begin
                if (lane_q == LANE_LAST) begin
                    state_d = COMPLETE;
                    hold_d  = '0;
                    done_d  = &lane_ok_q;
                    fail_d  = ~&lane_ok_q;
                end else begin
                    lane_d  = lane_q + LANE_W'(1);
                    retry_d = '0;
                    state_d = ISSUE;
                end
            end
            COMPLETE: begin
                if (ALIGN_REQ) begin
                    state_d = LOCK_WAIT;
`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
                end else if (period_q == PER_LAST) begin
                    state_d = LOCK_WAIT;
                end else begin
                    period_d = period_q + PER_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Lock loss aborts any active or completed sequence.
        if (!PLL_LOCK && (state_q inside {ISSUE, WAIT, NEXT, COMPLETE})) begin
            state_d = LOCK_WAIT;
        end

        if ((state_d == LOCK_WAIT) && (state_q != LOCK_WAIT)) begin
            lane_d    = '0;
            retry_d   = '0;
            armed_d   = 1'b0;
            tmo_cnt_d = '0;
            hold_d    = '1;
            lane_ok_d = '0;
            done_d    = 1'b0;
            fail_d    = 1'b0;
        end

        if (state_d == ISSUE) begin
            rstrt_d = lane_bit(lane_d);
            hold_d  = ~lane_bit(lane_d);
        end
        if (state_d == NEXT) hold_d[lane_q] = 1'b1;

        busy_d = state_d inside {LOCK_WAIT, ISSUE, WAIT, NEXT};
    end

    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            retry_q    <= '0;
            lane_q     <= '0;
            armed_q    <= 1'b0;
            rstrt_q    <= '0;
            hold_q     <= '1;
            lane_ok_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
            period_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            retry_q    <= retry_d;
            lane_q     <= lane_d;
            armed_q    <= armed_d;
            rstrt_q    <= rstrt_d;
            hold_q     <= hold_d;
            lane_ok_q  <= lane_ok_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
`ifdef RX_ALGN_PERIODIC_RETRAIN_EN
            period_q   <= period_d;
`endif
        end
    end

    assign LANE_RSTRT  = rstrt_q;
    assign LANE_HOLD   = hold_q;
    assign LANE_OK     = lane_ok_q;
    assign ACTIVE_LANE = lane_q;
    assign ALIGN_BUSY  = busy_q;
    assign ALIGN_DONE  = done_q;
    assign ALIGN_FAIL  = fail_q;

endmodule

// File: tb/tb_rx_lane_align_sequencer.sv
// Directed bench for rx_lane_align_sequencer: behavioural lane engines respond to restart pulses.
module tb_rx_lane_align_sequencer;

    localparam int NL = 4;
    localparam int M_GOOD   = 0;
    localparam int M_ERR    = 1;
    localparam int M_SILENT = 2;
    localparam int M_BOTH   = 3;

    logic          SCLK = 1'b0;
    logic          RESET;
    logic          PLL_LOCK;
    logic          ALIGN_REQ;
    logic [NL-1:0] LANE_START;
    logic [NL-1:0] LANE_DONE;
    logic [NL-1:0] LANE_ERR;
    logic [NL-1:0] LANE_RSTRT;
    logic [NL-1:0] LANE_HOLD;
    logic [NL-1:0] LANE_OK;
    logic [1:0]    ACTIVE_LANE;
    logic          ALIGN_BUSY;
    logic          ALIGN_DONE;
    logic          ALIGN_FAIL;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode[NL];
    int age[NL];
    int rstrt_cnt[NL];
    int last_rstrt[NL];
    int gap[NL];
    logic [15:0] order_log;

    rx_lane_align_sequencer #(
        .NUM_LANES      (NL),
        .LOCK_STABLE_CYC(8),
        .TIMEOUT_CYC    (100),
        .MAX_RETRY      (3)
    ) dut (
        .SCLK       (SCLK),
        .RESET      (RESET),
        .PLL_LOCK   (PLL_LOCK),
        .ALIGN_REQ  (ALIGN_REQ),
        .LANE_START (LANE_START),
        .LANE_DONE  (LANE_DONE),
        .LANE_ERR   (LANE_ERR),
        .LANE_RSTRT (LANE_RSTRT),
        .LANE_HOLD  (LANE_HOLD),
        .LANE_OK    (LANE_OK),
        .ACTIVE_LANE(ACTIVE_LANE),
        .ALIGN_BUSY (ALIGN_BUSY),
        .ALIGN_DONE (ALIGN_DONE),
        .ALIGN_FAIL (ALIGN_FAIL)
    );

    always #5 SCLK = ~SCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_log();
        for (int i = 0; i < NL; i++) begin
            age[i]        = -1;
            rstrt_cnt[i]  = 0;
            last_rstrt[i] = 0;
            gap[i]        = 0;
        end
        order_log = '0;
    endtask

    // One cycle: step to the falling edge, log restart pulses, update engine responses.
    task automatic tick();
        @(negedge SCLK);
        cyc++;
        for (int i = 0; i < NL; i++) begin
            if (LANE_RSTRT[i]) begin
                if (rstrt_cnt[i] > 0) gap[i] = cyc - last_rstrt[i];
                last_rstrt[i] = cyc;
                rstrt_cnt[i]++;
                order_log = {order_log[11:0], 4'(i)};
                age[i] = 0;
            end else if (age[i] >= 0) begin
                age[i]++;
            end
            case (mode[i])
                M_GOOD: begin
                    LANE_START[i] = (age[i] == 1);
                    LANE_DONE[i]  = (age[i] == 3);
                    LANE_ERR[i]   = 1'b0;
                end
                M_ERR: begin
                    LANE_START[i] = (age[i] == 1);
                    LANE_DONE[i]  = 1'b0;
                    LANE_ERR[i]   = (age[i] == 3);
                end
                M_SILENT: begin
                    LANE_START[i] = 1'b0;
                    LANE_DONE[i]  = 1'b1;
                    LANE_ERR[i]   = 1'b0;
                end
                default: begin
                    LANE_START[i] = (age[i] == 1);
                    LANE_DONE[i]  = (age[i] == 3);
                    LANE_ERR[i]   = (age[i] == 3);
                end
            endcase
        end
    endtask

    task automatic wait_complete(input int budget, output int t_done);
        int k;
        k = 0;
        while (!(ALIGN_DONE || ALIGN_FAIL) && k < budget) begin
            tick();
            k++;
        end
        check("complete_reached", 32'(ALIGN_DONE || ALIGN_FAIL), 32'd1);
        t_done = cyc;
    endtask

    task automatic restart_seq(input int m0, input int m1, input int m2, input int m3);
        mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
        clr_log();
        ALIGN_REQ = 1'b1;
        tick();
        ALIGN_REQ = 1'b0;
        check("req_clr_ok", 32'(LANE_OK), 32'h0);
        check("req_clr_status", 32'({ALIGN_DONE, ALIGN_FAIL}), 32'h0);
        check("req_busy", 32'(ALIGN_BUSY), 32'h1);
        check("req_hold", 32'(LANE_HOLD), 32'hF);
    endtask

    initial begin
        int t_first, t_done, k;
        RESET = 1'b1; PLL_LOCK = 1'b1; ALIGN_REQ = 1'b0;
        LANE_START = '0; LANE_DONE = '0; LANE_ERR = '0;
        for (int i = 0; i < NL; i++) mode[i] = M_GOOD;
        clr_log();
        repeat (3) tick();

        check("rst_rstrt", 32'(LANE_RSTRT), 32'h0);
        check("rst_hold", 32'(LANE_HOLD), 32'hF);
        check("rst_ok", 32'(LANE_OK), 32'h0);
        check("rst_lane", 32'(ACTIVE_LANE), 32'h0);
        check("rst_status", 32'({ALIGN_BUSY, ALIGN_DONE, ALIGN_FAIL}), 32'h0);

        // All lanes train cleanly; first restart on the 9th cycle of lock.
        RESET = 1'b0;
        tick();
        check("lockwait_busy", 32'(ALIGN_BUSY), 32'h1);
        repeat (7) tick();
        check("rstrt_not_early", 32'(LANE_RSTRT), 32'h0);
        tick();
        check("first_rstrt", 32'(LANE_RSTRT), 32'h1);
        check("first_hold", 32'(LANE_HOLD), 32'hE);
        t_first = cyc;
        wait_complete(200, t_done);
        check("s1_latency", 32'(t_done - t_first), 32'd20);
        check("s1_order", 32'(order_log), 32'h0123);
        check("s1_ok", 32'(LANE_OK), 32'hF);
        check("s1_done_fail", 32'({ALIGN_DONE, ALIGN_FAIL}), 32'h2);
        check("s1_hold", 32'(LANE_HOLD), 32'h0);
        check("s1_busy", 32'(ALIGN_BUSY), 32'h0);
        check("s1_lane", 32'(ACTIVE_LANE), 32'h3);

        // Lane 2 errors on every attempt.
        restart_seq(M_GOOD, M_GOOD, M_ERR, M_GOOD);
        wait_complete(300, t_done);
        check("s2_rstrt_lane2", 32'(rstrt_cnt[2]), 32'd4);
        check("s2_gap_lane2", 32'(gap[2]), 32'd4);
        check("s2_rstrt_lane0", 32'(rstrt_cnt[0]), 32'd1);
        check("s2_ok", 32'(LANE_OK), 32'hB);
        check("s2_done_fail", 32'({ALIGN_DONE, ALIGN_FAIL}), 32'h1);

        // Lane 1 never starts while holding a stale DONE: timeouts only.
        restart_seq(M_GOOD, M_SILENT, M_GOOD, M_GOOD);
        wait_complete(1000, t_done);
        check("s3_rstrt_lane1", 32'(rstrt_cnt[1]), 32'd4);
        check("s3_timeout_gap", 32'(gap[1]), 32'd101);
        check("s3_ok", 32'(LANE_OK), 32'hD);
        check("s3_done_fail", 32'({ALIGN_DONE, ALIGN_FAIL}), 32'h1);

        // Lane 3 reports DONE and ERR together: treated as error.
        restart_seq(M_GOOD, M_GOOD, M_GOOD, M_BOTH);
        wait_complete(300, t_done);
        check("s4_rstrt_lane3", 32'(rstrt_cnt[3]), 32'd4);
        check("s4_ok", 32'(LANE_OK), 32'h7);
        check("s4_done_fail", 32'({ALIGN_DONE, ALIGN_FAIL}), 32'h1);

        // Lock loss while waiting on lane 2, then relock.
        restart_seq(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        k = 0;
        while (rstrt_cnt[2] == 0 && k < 200) begin
            tick();
            k++;
        end
        check("s5_reach_lane2", 32'(rstrt_cnt[2]), 32'd1);
        tick();
        check("s5_ok_before", 32'(LANE_OK), 32'h3);
        PLL_LOCK = 1'b0;
        tick();
        check("s5_abort_hold", 32'(LANE_HOLD), 32'hF);
        check("s5_abort_ok", 32'(LANE_OK), 32'h0);
        check("s5_abort_busy", 32'(ALIGN_BUSY), 32'h1);
        check("s5_abort_rstrt", 32'(LANE_RSTRT), 32'h0);
        check("s5_abort_lane", 32'(ACTIVE_LANE), 32'h0);
        PLL_LOCK = 1'b1;
        clr_log();
        repeat (7) tick();
        check("s5_relock_early", 32'(LANE_RSTRT), 32'h0);
        tick();
        check("s5_relock_rstrt", 32'(LANE_RSTRT), 32'h1);
        wait_complete(200, t_done);
        check("s5_ok", 32'(LANE_OK), 32'hF);
        check("s5_done_fail", 32'({ALIGN_DONE, ALIGN_FAIL}), 32'h2);

        // Reset in mid-sequence discards partial status.
        restart_seq(M_GOOD, M_GOOD, M_GOOD, M_GOOD);
        k = 0;
        while (rstrt_cnt[1] == 0 && k < 200) begin
            tick();
            k++;
        end
        check("s6_ok_before", 32'(LANE_OK), 32'h1);
        RESET = 1'b1;
        tick();
        check("s6_rst_ok", 32'(LANE_OK), 32'h0);
        check("s6_rst_hold", 32'(LANE_HOLD), 32'hF);
        check("s6_rst_status", 32'({ALIGN_BUSY, ALIGN_DONE, ALIGN_FAIL}), 32'h0);
        check("s6_rst_lane", 32'(ACTIVE_LANE), 32'h0);
        RESET = 1'b0;
        tick();
        check("s6_restart_busy", 32'(ALIGN_BUSY), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
